// File: rtl/mipi_csi_packet_encoder.sv
// CSI-2 transmit packet encoder: FS/FE short packets and long packets
// with ECC header, 4-lane payload, CRC-16 footer and LP gaps.
module mipi_csi_packet_encoder #(
  parameter logic [5:0] DATA_TYPE = 6'h2B,
  parameter logic [1:0] VC        = 2'd0,
  parameter int         LP_GAP    = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        fs_req_i,
  input  logic        fe_req_i,
  input  logic        line_req_i,
  input  logic [15:0] line_wc_i,
  output logic        req_ready_o,
  input  logic [31:0] data_i,
  input  logic        data_valid_i,
  output logic        data_ready_o,
  output logic [31:0] hs_data_o,
  output logic [3:0]  hs_lane_valid_o,
  output logic        hs_valid_o,
  output logic        underrun_o
);

  typedef enum logic [2:0] {
    IDLE, SOT, HEADER, PAYLOAD, FOOTER, GAP
  } state_t;

  state_t      state, state_n;
  logic [15:0] frame_cnt, frame_cnt_n;
  logic [7:0]  pkt_di, pkt_di_n;
  logic [15:0] pkt_wc, pkt_wc_n;
  logic        pkt_long, pkt_long_n;
  logic [13:0] rem, rem_n;
  logic [15:0] crc, crc_n;
  logic [15:0] gap_cnt, gap_cnt_n;
  logic [31:0] hs_data_n;
  logic [3:0]  lane_n;
  logic        hs_valid_n;
  logic        data_ready_n;
  logic        underrun_n;
  logic        req_ready_n;
  logic [15:0] fc_inc;
  logic [31:0] word;

  // 6-bit Hamming ECC over {WC,DI}, bit 0 = DI[0]
  function automatic logic [7:0] ecc6(input logic [23:0] d);
    logic [7:0] e;
    e = 8'h00;
    e[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]
         ^ d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    e[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]
         ^ d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    e[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]
         ^ d[15]^d[18]^d[20]^d[21]^d[22];
    e[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]
         ^ d[15]^d[19]^d[20]^d[21]^d[23];
    e[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]
         ^ d[18]^d[19]^d[20]^d[22]^d[23];
    e[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]
         ^ d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return e;
  endfunction

  // reflected CRC-16 (0x8408), bits taken LSB first, byte0 first
  function automatic logic [15:0] crc_word(
    input logic [15:0] c,
    input logic [31:0] d
  );
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 32; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'h8408;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign fc_inc = (frame_cnt == 16'hFFFF) ? 16'h0001
                                          : frame_cnt + 16'h0001;
  assign word   = data_valid_i ? data_i : 32'h0;

  // state and registered outputs
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state           <= IDLE;
      frame_cnt       <= 16'h0;
      pkt_di          <= 8'h0;
      pkt_wc          <= 16'h0;
      pkt_long        <= 1'b0;
      rem             <= 14'h0;
      crc             <= 16'hFFFF;
      gap_cnt         <= 16'h0;
      hs_data_o       <= 32'h0;
      hs_lane_valid_o <= 4'h0;
      hs_valid_o      <= 1'b0;
      data_ready_o    <= 1'b0;
      underrun_o      <= 1'b0;
      req_ready_o     <= 1'b1;
    end else begin
      state           <= state_n;
      frame_cnt       <= frame_cnt_n;
      pkt_di          <= pkt_di_n;
      pkt_wc          <= pkt_wc_n;
      pkt_long        <= pkt_long_n;
      rem             <= rem_n;
      crc             <= crc_n;
      gap_cnt         <= gap_cnt_n;
      hs_data_o       <= hs_data_n;
      hs_lane_valid_o <= lane_n;
      hs_valid_o      <= hs_valid_n;
      data_ready_o    <= data_ready_n;
      underrun_o      <= underrun_n;
      req_ready_o     <= req_ready_n;
    end
  end

  // next state and next output values
  always_comb begin
    state_n      = state;
    frame_cnt_n  = frame_cnt;
    pkt_di_n     = pkt_di;
    pkt_wc_n     = pkt_wc;
    pkt_long_n   = pkt_long;
    rem_n        = rem;
    crc_n        = crc;
    gap_cnt_n    = gap_cnt;
    hs_data_n    = 32'h0;
    lane_n       = 4'h0;
    hs_valid_n   = 1'b0;
    data_ready_n = 1'b0;
    underrun_n   = underrun_o;
    req_ready_n  = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready_n = 1'b1;
        if (fs_req_i || line_req_i || fe_req_i) begin
          state_n     = SOT;
          hs_data_n   = 32'hB8B8B8B8;
          lane_n      = 4'hF;
          hs_valid_n  = 1'b1;
          req_ready_n = 1'b0;
          crc_n       = 16'hFFFF;
          if (fs_req_i) begin
            frame_cnt_n = fc_inc;
            pkt_di_n    = {VC, 6'h00};
            pkt_wc_n    = fc_inc;
            pkt_long_n  = 1'b0;
          end else if (line_req_i) begin
            pkt_di_n    = {VC, DATA_TYPE};
            pkt_wc_n    = line_wc_i & 16'hFFFC;
            pkt_long_n  = 1'b1;
          end else begin
            pkt_di_n    = {VC, 6'h01};
            pkt_wc_n    = frame_cnt;
            pkt_long_n  = 1'b0;
          end
        end
      end
      SOT: begin
        state_n      = HEADER;
        hs_data_n    = {ecc6({pkt_wc, pkt_di}),
                        pkt_wc[15:8], pkt_wc[7:0], pkt_di};
        lane_n       = 4'hF;
        hs_valid_n   = 1'b1;
        rem_n        = pkt_wc[15:2];
        data_ready_n = pkt_long && (pkt_wc[15:2] != 14'h0);
      end
      HEADER, PAYLOAD: begin
        if (data_ready_o) begin
          state_n      = PAYLOAD;
          hs_data_n    = word;
          lane_n       = 4'hF;
          hs_valid_n   = 1'b1;
          crc_n        = crc_word(crc, word);
          rem_n        = rem - 14'h1;
          data_ready_n = (rem != 14'h1);
          if (!data_valid_i) underrun_n = 1'b1;
        end else if (pkt_long) begin
          state_n    = FOOTER;
          hs_data_n  = {16'h0, crc};
          lane_n     = 4'h3;
          hs_valid_n = 1'b1;
        end else begin
          state_n   = GAP;
          gap_cnt_n = 16'(LP_GAP - 1);
        end
      end
      FOOTER: begin
        state_n   = GAP;
        gap_cnt_n = 16'(LP_GAP - 1);
      end
      GAP: begin
        if (gap_cnt == 16'h0) begin
          state_n     = IDLE;
          req_ready_n = 1'b1;
        end else begin
          gap_cnt_n = gap_cnt - 16'h1;
        end
      end
      default: begin
        state_n     = IDLE;
        req_ready_n = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_mipi_csi_packet_encoder.sv
// Directed bench for mipi_csi_packet_encoder: short/long packets,
// CRC/ECC values, underrun, priority, frame wrap, mid-packet reset.
module tb_mipi_csi_packet_encoder;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        fs_req_i, fe_req_i, line_req_i;
  logic [15:0] line_wc_i;
  logic        req_ready_o;
  logic [31:0] data_i;
  logic        data_valid_i;
  logic        data_ready_o;
  logic [31:0] hs_data_o;
  logic [3:0]  hs_lane_valid_o;
  logic        hs_valid_o;
  logic        underrun_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] pay [6] = '{
    32'h020000FF, 32'h72F3DCB9, 32'h5AB8D4BB,
    32'h7CC275C8, 32'hDF05F881, 32'h010000FF
  };

  mipi_csi_packet_encoder dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .fs_req_i       (fs_req_i),
    .fe_req_i       (fe_req_i),
    .line_req_i     (line_req_i),
    .line_wc_i      (line_wc_i),
    .req_ready_o    (req_ready_o),
    .data_i         (data_i),
    .data_valid_i   (data_valid_i),
    .data_ready_o   (data_ready_o),
    .hs_data_o      (hs_data_o),
    .hs_lane_valid_o(hs_lane_valid_o),
    .hs_valid_o     (hs_valid_o),
    .underrun_o     (underrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [15:0] crc_byte(
    input logic [15:0] c,
    input logic [7:0]  b
  );
    logic [15:0] r;
    r = c ^ {8'h00, b};
    repeat (8) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  task automatic gap_done(input string tag);
    for (int i = 0; i < 8; i++) begin
      tick();
      check({tag, "_gap_v"}, 32'(hs_valid_o), 32'h0);
      check({tag, "_gap_d"}, hs_data_o, 32'h0);
      check({tag, "_gap_rdy"}, 32'(req_ready_o), 32'h0);
    end
    tick();
    check({tag, "_rdy"}, 32'(req_ready_o), 32'h1);
  endtask

  task automatic short_pkt(
    input logic        fs,
    input logic        fe,
    input logic        line,
    input logic [31:0] hdr,
    input string       tag
  );
    check({tag, "_pre_rdy"}, 32'(req_ready_o), 32'h1);
    fs_req_i   = fs;
    fe_req_i   = fe;
    line_req_i = line;
    line_wc_i  = 16'd24;
    tick();
    fs_req_i   = 1'b0;
    fe_req_i   = 1'b0;
    line_req_i = 1'b1;
    check({tag, "_sot"}, hs_data_o, 32'hB8B8B8B8);
    check({tag, "_sot_lv"}, 32'(hs_lane_valid_o), 32'hF);
    check({tag, "_sot_v"}, 32'(hs_valid_o), 32'h1);
    check({tag, "_busy_rdy"}, 32'(req_ready_o), 32'h0);
    tick();
    line_req_i = 1'b0;
    check({tag, "_hdr"}, hs_data_o, hdr);
    check({tag, "_hdr_v"}, 32'(hs_valid_o), 32'h1);
    check({tag, "_hdr_dr"}, 32'(data_ready_o), 32'h0);
    gap_done(tag);
  endtask

  task automatic line_pkt(
    input int    bad,
    input int    abort,
    input string tag
  );
    logic [15:0] crc;
    logic [31:0] w;
    crc        = 16'hFFFF;
    line_req_i = 1'b1;
    line_wc_i  = 16'd27;
    tick();
    line_req_i = 1'b0;
    check({tag, "_sot"}, hs_data_o, 32'hB8B8B8B8);
    tick();
    check({tag, "_hdr"}, hs_data_o, 32'h1400182B);
    check({tag, "_hdr_dr"}, 32'(data_ready_o), 32'h1);
    data_i       = pay[0];
    data_valid_i = (bad != 0);
    for (int j = 0; j < 6; j++) begin
      tick();
      w = (j == bad) ? 32'h0 : pay[j];
      check({tag, "_pay"}, hs_data_o, w);
      check({tag, "_pay_lv"}, 32'(hs_lane_valid_o), 32'hF);
      check({tag, "_pay_dr"}, 32'(data_ready_o),
            (j < 5) ? 32'h1 : 32'h0);
      for (int b = 0; b < 4; b++)
        crc = crc_byte(crc, w[8*b +: 8]);
      if (j < 5) begin
        data_i       = pay[j+1];
        data_valid_i = (bad != j + 1);
      end else begin
        data_valid_i = 1'b0;
      end
      if (abort == j) begin
        reset_i = 1'b0;
        tick();
        reset_i = 1'b1;
        data_valid_i = 1'b0;
        check({tag, "_rst_d"}, hs_data_o, 32'h0);
        check({tag, "_rst_lv"}, 32'(hs_lane_valid_o), 32'h0);
        check({tag, "_rst_v"}, 32'(hs_valid_o), 32'h0);
        check({tag, "_rst_dr"}, 32'(data_ready_o), 32'h0);
        check({tag, "_rst_ur"}, 32'(underrun_o), 32'h0);
        check({tag, "_rst_rdy"}, 32'(req_ready_o), 32'h1);
        for (int k = 0; k < 4; k++) begin
          tick();
          check({tag, "_nofoot"}, 32'(hs_valid_o), 32'h0);
        end
        return;
      end
    end
    tick();
    check({tag, "_foot"}, hs_data_o,
          (bad < 0) ? 32'h000000F0 : {16'h0, crc});
    check({tag, "_foot_lv"}, 32'(hs_lane_valid_o), 32'h3);
    check({tag, "_foot_v"}, 32'(hs_valid_o), 32'h1);
    gap_done(tag);
  endtask

  initial begin
    reset_i      = 1'b0;
    fs_req_i     = 1'b0;
    fe_req_i     = 1'b0;
    line_req_i   = 1'b0;
    line_wc_i    = 16'h0;
    data_i       = 32'h0;
    data_valid_i = 1'b0;
    repeat (3) tick();
    reset_i = 1'b1;
    check("rst_data", hs_data_o, 32'h0);
    check("rst_lv", 32'(hs_lane_valid_o), 32'h0);
    check("rst_valid", 32'(hs_valid_o), 32'h0);
    check("rst_dready", 32'(data_ready_o), 32'h0);
    check("rst_underrun", 32'(underrun_o), 32'h0);
    check("rst_rready", 32'(req_ready_o), 32'h1);

    short_pkt(1'b1, 1'b0, 1'b0, 32'h1A000100, "fs1");
    short_pkt(1'b0, 1'b1, 1'b0, 32'h1D000101, "fe1");
    short_pkt(1'b1, 1'b0, 1'b0, 32'h1C000200, "fs2");

    line_pkt(-1, -1, "line");
    check("ur_clean", 32'(underrun_o), 32'h0);
    line_pkt(2, -1, "line_ur");
    check("ur_set", 32'(underrun_o), 32'h1);

    short_pkt(1'b1, 1'b0, 1'b1, 32'h06000300, "fs_line");
    check("ur_sticky", 32'(underrun_o), 32'h1);

    force dut.frame_cnt = 16'hFFFF;
    tick();
    short_pkt(1'b1, 1'b0, 1'b0, 32'h1A000100, "fs_wrap");
    release dut.frame_cnt;
    tick();

    line_pkt(-1, 2, "line_abort");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
